// File: rtl/sphere_pkg.sv
// Shared shading constants, intensity mapping and initial-position formula.
package sphere_pkg;

    localparam int unsigned CORE_OFS    = 128;
    localparam int unsigned FALL_SHIFT  = 7;
    localparam int unsigned MAX_INT     = 15;
    localparam int unsigned INIT_BASE   = 128;
    localparam int unsigned INIT_H_STEP = 64;
    localparam int unsigned INIT_V_STEP = 32;

    // Squared distance to 4-bit intensity: flat core, linear falloff, then dark.
    function automatic logic [3:0] shade(input int unsigned d,
                                         input int unsigned radius_sq,
                                         input int unsigned halo);
        int unsigned lvl;
        logic [3:0]  res;
        lvl = 0;
        res = 4'd0;
        if (d < radius_sq + CORE_OFS) begin
            res = 4'(MAX_INT);
        end else if (d < radius_sq + halo) begin
            lvl = (d - radius_sq) >> FALL_SHIFT;
            if (lvl < MAX_INT) begin
                res = 4'(MAX_INT - lvl);
            end
        end
        return res;
    endfunction

    // Reset column of sphere idx.
    function automatic int unsigned init_h(input int unsigned idx);
        return INIT_BASE + INIT_H_STEP * idx;
    endfunction

    // Reset row of sphere idx.
    function automatic int unsigned init_v(input int unsigned idx);
        return INIT_BASE + INIT_V_STEP * idx;
    endfunction

endpackage

// File: rtl/sphere_motion.sv
// Centre, direction and edge-bounce state for one sphere.
module sphere_motion
    import sphere_pkg::*;
#(
    parameter int unsigned COORD_W = 10,
    parameter int unsigned H_RES   = 640,
    parameter int unsigned V_RES   = 480,
    parameter int unsigned MARGIN  = 32,
    parameter int unsigned IDX     = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               step_i,
    input  logic [1:0]         start_dir_i,
    output logic [COORD_W-1:0] ch_o,
    output logic [COORD_W-1:0] cv_o,
    output logic               bounce_o
);

    localparam logic [COORD_W-1:0] LO    = COORD_W'(MARGIN);
    localparam logic [COORD_W-1:0] H_HI  = COORD_W'(H_RES - MARGIN);
    localparam logic [COORD_W-1:0] V_HI  = COORD_W'(V_RES - MARGIN);
    localparam logic [COORD_W-1:0] ONE   = COORD_W'(1);
    localparam logic [COORD_W-1:0] H_RST = COORD_W'(init_h(IDX));
    localparam logic [COORD_W-1:0] V_RST = COORD_W'(init_v(IDX));

    logic [COORD_W-1:0] ch_q, ch_d, cv_q, cv_d;
    logic               hdir_q, hdir_d, vdir_q, vdir_d;
    logic               hdir_n, vdir_n;
    logic               bounce_q, bounce_d;

    // Direction is resolved against the margins first, then the centre moves one pixel.
    always_comb begin
        hdir_n   = hdir_q;
        vdir_n   = vdir_q;
        ch_d     = ch_q;
        cv_d     = cv_q;
        hdir_d   = hdir_q;
        vdir_d   = vdir_q;
        bounce_d = 1'b0;
        if (ch_q <= LO) begin
            hdir_n = 1'b1;
        end else if (ch_q >= H_HI) begin
            hdir_n = 1'b0;
        end
        if (cv_q <= LO) begin
            vdir_n = 1'b1;
        end else if (cv_q >= V_HI) begin
            vdir_n = 1'b0;
        end
        if (step_i) begin
            hdir_d   = hdir_n;
            vdir_d   = vdir_n;
            ch_d     = hdir_n ? ch_q + ONE : ch_q - ONE;
            cv_d     = vdir_n ? cv_q + ONE : cv_q - ONE;
            bounce_d = (hdir_n != hdir_q) || (vdir_n != vdir_q);
        end
    end

    // State register; reset places the sphere at its slot and loads start directions.
    always_ff @(posedge clk) begin
        if (reset) begin
            ch_q     <= H_RST;
            cv_q     <= V_RST;
            hdir_q   <= start_dir_i[0];
            vdir_q   <= start_dir_i[1];
            bounce_q <= 1'b0;
        end else begin
            ch_q     <= ch_d;
            cv_q     <= cv_d;
            hdir_q   <= hdir_d;
            vdir_q   <= vdir_d;
            bounce_q <= bounce_d;
        end
    end

    assign ch_o     = ch_q;
    assign cv_o     = cv_q;
    assign bounce_o = bounce_q;

endmodule

// File: rtl/multi_sphere_renderer.sv
// Renders N_SPHERES bouncing shaded spheres into a 4-bit intensity stream.
module multi_sphere_renderer
    import sphere_pkg::*;
#(
    parameter int unsigned N_SPHERES = 4,
    parameter int unsigned COORD_W   = 10,
    parameter int unsigned H_RES     = 640,
    parameter int unsigned V_RES     = 480,
    parameter int unsigned MARGIN    = 32,
    parameter int unsigned RADIUS_SQ = 512,
    parameter int unsigned HALO      = 2048,
    parameter int unsigned DIV_W     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [COORD_W-1:0]     h_pos,
    input  logic [COORD_W-1:0]     v_pos,
    input  logic                   pix_valid,
    input  logic                   frame_tick,
    input  logic                   enable,
    input  logic [DIV_W-1:0]       speed_div,
    input  logic [2*N_SPHERES-1:0] start_dir,
    output logic [3:0]             colorv,
    output logic                   color_valid,
    output logic [N_SPHERES-1:0]   bounce_evt
);

    localparam int unsigned SQ_W = 2 * COORD_W;
    localparam int unsigned D_W  = 2 * COORD_W + 1;

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             step_c;
    logic [D_W-1:0]   d_d [N_SPHERES];
    logic [D_W-1:0]   d_q [N_SPHERES];
    logic [3:0]       shade_c [N_SPHERES];
    logic             s1_valid_q;
    logic [3:0]       max_c, colorv_d, colorv_q;
    logic             color_valid_q;

    // Frame counter: one motion step every speed_div+1 enabled frame ticks.
    always_comb begin
        cnt_d  = cnt_q;
        step_c = 1'b0;
        if (frame_tick && enable) begin
            if (cnt_q == speed_div) begin
                cnt_d  = '0;
                step_c = 1'b1;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    // Frame counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    for (genvar g = 0; g < N_SPHERES; g++) begin : g_sph
        logic [COORD_W-1:0] centre_h, centre_v, dx, dy;
        logic [SQ_W-1:0]    sqx, sqy;

        sphere_motion #(
            .COORD_W (COORD_W),
            .H_RES   (H_RES),
            .V_RES   (V_RES),
            .MARGIN  (MARGIN),
            .IDX     (g)
        ) u_motion (
            .clk         (clk),
            .reset       (reset),
            .step_i      (step_c),
            .start_dir_i (start_dir[2*g +: 2]),
            .ch_o        (centre_h),
            .cv_o        (centre_v),
            .bounce_o    (bounce_evt[g])
        );

        // True absolute differences, no modular wrap.
        assign dx       = (h_pos >= centre_h) ? h_pos - centre_h : centre_h - h_pos;
        assign dy       = (v_pos >= centre_v) ? v_pos - centre_v : centre_v - v_pos;
        assign sqx      = SQ_W'(dx) * SQ_W'(dx);
        assign sqy      = SQ_W'(dy) * SQ_W'(dy);
        assign d_d[g]   = D_W'(sqx) + D_W'(sqy);
        assign shade_c[g] = shade(32'(d_q[g]), RADIUS_SQ, HALO);
    end

    // S1 squared-distance registers; data needs no reset, validity is tracked separately.
    always_ff @(posedge clk) begin
        d_q <= d_d;
    end

    // S2 compositing: brightest sphere wins, blanked when the pixel was not visible.
    always_comb begin
        max_c = '0;
        for (int i = 0; i < N_SPHERES; i++) begin
            if (shade_c[i] > max_c) begin
                max_c = shade_c[i];
            end
        end
        colorv_d = s1_valid_q ? max_c : 4'd0;
    end

    // Pipeline valid and output registers; reset flushes the pipe.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q    <= 1'b0;
            colorv_q      <= '0;
            color_valid_q <= 1'b0;
        end else begin
            s1_valid_q    <= pix_valid;
            colorv_q      <= colorv_d;
            color_valid_q <= s1_valid_q;
        end
    end

    assign colorv      = colorv_q;
    assign color_valid = color_valid_q;

endmodule
